// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate sequential multiplier:
// controller state encoding and shift-count width derivation.
package approx_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_MUL    = 3'd2,
        ST_DENORM = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of one leading-zero shift count (holds 0..N).
    function automatic int shift_w(input int n);
        return clog2(n) + 1;
    endfunction

endpackage

// File: rtl/approx_seq_multiplier_shift_add_core.sv
// Iterative shift-add multiplier core. Multiplies an m_len-bit ta by an
// m_len-bit tb (both right-aligned) in m_len cycles after a load pulse.
// Registers are sized for the full N-bit case.
module shift_add_core
    import approx_mul_pkg::*;
#(
    parameter int N = 16,
    localparam int SW = shift_w(N),
    localparam int PW = 2 * N
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [SW-1:0] m_len_i,
    input  logic [N-1:0]  ta_i,
    input  logic [N-1:0]  tb_i,
    output logic [PW-1:0] p_o,
    output logic          last_o
);

    logic [N:0]    acc_q;
    logic [N-1:0]  mq_q;
    logic [N-1:0]  ta_q;
    logic [SW-1:0] cnt_q;
    logic [SW-1:0] gap_q;
    logic          run_q;
    logic [N:0]    sum;
    logic [PW:0]   pair;

    // Conditional add of the multiplicand; the carry lands in acc's top bit.
    assign sum    = acc_q + (mq_q[0] ? {1'b0, ta_q} : '0);
    assign pair   = {acc_q, mq_q};
    // Low product bits enter mq at its top, so with m_len < N the
    // result sits N-m_len positions too high in the pair.
    assign p_o    = PW'(pair >> gap_q);
    assign last_o = run_q && (cnt_q == '0);

    // Load operands, then run one shift-add step per cycle until the count expires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            mq_q  <= '0;
            ta_q  <= '0;
            cnt_q <= '0;
            gap_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= '0;
            mq_q  <= tb_i;
            ta_q  <= ta_i;
            cnt_q <= m_len_i - SW'(1);
            gap_q <= SW'(N) - m_len_i;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= {1'b0, sum[N:1]};
            mq_q  <= {sum[0], mq_q[N-1:1]};
            cnt_q <= cnt_q - SW'(1);
            if (cnt_q == '0) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/approx_seq_multiplier.sv
// Sequential multiplier with leading-one normalisation. Approximate mode
// multiplies only the top K bits of each normalised operand; exact mode
// uses all N bits. Result is denormalised back to a 2N-bit product.
module approx_seq_multiplier
    import approx_mul_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic           exact_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] product_o
);

    localparam int SW   = shift_w(N);
    localparam int SH_W = SW + 1;

    state_e         state_q;
    logic [N-1:0]   ra_q, rb_q;
    logic           mode_q;
    logic [SW-1:0]  sa_q, sb_q;
    logic           busy_q, done_q;
    logic [2*N-1:0] product_q;

    logic [SW-1:0]  m_len;
    logic [N-1:0]   ta, tb;
    logic           load;
    logic           core_last;
    logic [2*N-1:0] core_p;
    logic [SH_W-1:0] up_sh, dn_sh;
    logic [2*N-1:0] denorm;

    assign m_len  = mode_q ? SW'(N) : SW'(K);
    assign ta     = ra_q >> (SW'(N) - m_len);
    assign tb     = rb_q >> (SW'(N) - m_len);
    assign load   = (state_q == ST_NORM) && ra_q[N-1] && rb_q[N-1];
    // Re-align the 2M-bit product to 2N bits, then undo both normalisation shifts.
    assign up_sh  = SH_W'(2 * N) - {m_len, 1'b0};
    assign dn_sh  = {1'b0, sa_q} + {1'b0, sb_q};
    assign denorm = (core_p << up_sh) >> dn_sh;

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

    shift_add_core #(.N(N)) u_core (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .m_len_i(m_len),
        .ta_i   (ta),
        .tb_i   (tb),
        .p_o    (core_p),
        .last_o (core_last)
    );

    // Controller FSM with registered busy/done/product.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            mode_q    <= 1'b0;
            sa_q      <= '0;
            sb_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        ra_q   <= a_i;
                        rb_q   <= b_i;
                        mode_q <= exact_i;
                        sa_q   <= '0;
                        sb_q   <= '0;
                        busy_q <= 1'b1;
                        if (a_i == '0 || b_i == '0) begin
                            product_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    if (load) begin
                        state_q <= ST_MUL;
                    end else begin
                        if (!ra_q[N-1]) begin
                            ra_q <= {ra_q[N-2:0], 1'b0};
                            sa_q <= sa_q + SW'(1);
                        end
                        if (!rb_q[N-1]) begin
                            rb_q <= {rb_q[N-2:0], 1'b0};
                            sb_q <= sb_q + SW'(1);
                        end
                    end
                end
                ST_MUL: begin
                    if (core_last) state_q <= ST_DENORM;
                end
                ST_DENORM: begin
                    product_q <= denorm;
                    done_q    <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_seq_multiplier.sv
// Self-checking bench for approx_seq_multiplier (N=16, K=8).
module tb_approx_seq_multiplier;

    localparam int N = 16;
    localparam int K = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           exact;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_cmp;
    int n_err;

    approx_seq_multiplier #(.N(N), .K(K)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .exact_i  (exact),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .product_o(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: leading zeros, truncated-operand product, latency.
    function automatic int lz(input logic [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) if (v[i]) return N - 1 - i;
        return N;
    endfunction

    function automatic longint ref_prod(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ex);
        longint la, lb, ta, tb, m, p;
        if (av == 0 || bv == 0) return 0;
        if (ex) return longint'(av) * longint'(bv);
        m  = K;
        la = lz(av);
        lb = lz(bv);
        ta = ((longint'(av) << la) & ((64'd1 << N) - 1)) >> (N - m);
        tb = ((longint'(bv) << lb) & ((64'd1 << N) - 1)) >> (N - m);
        p  = ta * tb;
        return ((p << (2 * N - 2 * m)) >> (la + lb)) & ((64'd1 << (2 * N)) - 1);
    endfunction

    function automatic int ref_lat(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ex);
        int la, lb;
        if (av == 0 || bv == 0) return 1;
        la = lz(av);
        lb = lz(bv);
        return ((la > lb) ? la : lb) + (ex ? N : K) + 3;
    endfunction

    // Issue one operation once the DUT is idle; report latency and product.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ex,
                          output logic [2*N-1:0] prod, output int lat, output bit busy_drop);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        a = av; b = bv; exact = ex; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); exact = 1'($urandom);
        lat = 1;
        busy_drop = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_drop = 1;
            @(posedge clk); #1;
            lat++;
        end
        prod = product;
    endtask

    task automatic test_reset;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (product !== '0) begin n_err++; $display("FAIL reset_product: got %h want 0", product); end
    endtask

    task automatic test_directed;
        logic [N-1:0]   av [5] = '{16'hFFFF, 16'hFFFF, 16'h0003, 16'h1FFF, 16'h1FFF};
        logic [N-1:0]   bv [5] = '{16'hFFFF, 16'hFFFF, 16'h0005, 16'h0100, 16'h0100};
        logic           ev [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2*N-1:0] ep [5] = '{32'hFE010000, 32'hFFFE0001, 32'h0000000F, 32'h001FE000, 32'h001FFF00};
        int             el [5] = '{11, 19, 25, 18, 26};
        logic [2*N-1:0] p;
        int lat;
        bit bd;
        for (int i = 0; i < 5; i++) begin
            run_op(av[i], bv[i], ev[i], p, lat, bd);
            n_cmp++; if (p !== ep[i]) begin n_err++; $display("FAIL directed_product[%0d]: got %h want %h", i, p, ep[i]); end
            n_cmp++; if (lat != el[i]) begin n_err++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, el[i]); end
            n_cmp++; if (bd) begin n_err++; $display("FAIL directed_busy[%0d]: busy dropped got 1 want 0", i); end
        end
    endtask

    task automatic test_zero;
        logic [2*N-1:0] p;
        int lat;
        bit bd;
        run_op(16'h1234, 16'h0000, 1'b0, p, lat, bd);
        n_cmp++; if (p !== '0) begin n_err++; $display("FAIL zero_b_product: got %h want 0", p); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL zero_b_latency: got %0d want 1", lat); end
        run_op(16'h0000, 16'hFFFF, 1'b1, p, lat, bd);
        n_cmp++; if (p !== '0) begin n_err++; $display("FAIL zero_a_product: got %h want 0", p); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL zero_a_latency: got %0d want 1", lat); end
    endtask

    task automatic test_ignore_start;
        int lat;
        bit extra;
        @(negedge clk);
        while (busy) @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; exact = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 3) begin
                start = 1'b1; a = 16'h0003; b = 16'h0005; exact = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        // Now in the DONE cycle: a start here must be dropped too.
        start = 1'b1; a = 16'h0007; b = 16'h0009; exact = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (lat != 11) begin n_err++; $display("FAIL ignore_latency: got %0d want 11", lat); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy || product !== 32'hFE010000) extra = 1;
            @(posedge clk); #1;
        end
        n_cmp++; if (extra) begin n_err++; $display("FAIL ignore_no_restart: got activity/changed product %h want idle FE010000", product); end
        n_cmp++; if (product !== 32'hFE010000) begin n_err++; $display("FAIL ignore_product: got %h want FE010000", product); end
    endtask

    task automatic test_reset_mid;
        logic [2*N-1:0] p;
        int lat;
        bit bd, seen;
        @(negedge clk);
        while (busy) @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; exact = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", done); end
        n_cmp++; if (product !== '0) begin n_err++; $display("FAIL midreset_product: got %h want 0", product); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL midreset_abort: got done/busy activity want none"); end
        run_op(16'h0003, 16'h0005, 1'b1, p, lat, bd);
        n_cmp++; if (p !== 32'h0000000F) begin n_err++; $display("FAIL midreset_after_product: got %h want 0000000F", p); end
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL midreset_after_latency: got %0d want 33", lat); end
    endtask

    task automatic test_random;
        logic [N-1:0]   av, bv;
        logic [2*N-1:0] p, exp_p;
        int lat, exp_l, nb;
        bit bd, moved;
        for (int i = 0; i < 1000; i++) begin
            nb = $urandom_range(0, N);
            av = N'($urandom) & N'((32'd1 << nb) - 1);
            nb = $urandom_range(1, N);
            bv = N'($urandom) & N'((32'd1 << nb) - 1);
            for (int m = 0; m < 2; m++) begin
                run_op(av, bv, 1'(m), p, lat, bd);
                exp_p = 32'(ref_prod(av, bv, 1'(m)));
                exp_l = ref_lat(av, bv, 1'(m));
                n_cmp++; if (p !== exp_p) begin n_err++; $display("FAIL random_product a=%h b=%h ex=%0d: got %h want %h", av, bv, m, p, exp_p); end
                n_cmp++; if (lat != exp_l) begin n_err++; $display("FAIL random_latency a=%h b=%h ex=%0d: got %0d want %0d", av, bv, m, lat, exp_l); end
                moved = 0;
                for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
                    @(posedge clk); #1;
                    if (product !== p) moved = 1;
                end
                n_cmp++; if (moved) begin n_err++; $display("FAIL random_hold a=%h b=%h: got %h want %h", av, bv, product, p); end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        exact = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/approx_seq_multiplier.md
Name: approx_seq_multiplier

Overview:
- Parametrised successor to the team's fixed-width effective-bit shift-add multiplier datapath.
- Integrates controller and datapath in one block with a start/done handshake.
- Normalises each N-bit unsigned operand by leading-one left shift, then multiplies the top K bits (approximate mode) or all N bits (exact mode) by iterative shift-add.
- Denormalises the result back to a 2N-bit product.

Parameters:
N, 16, operand width; N >= 4.
K, 8, effective bits used in approximate mode; 2 <= K <= N.
SW, derived localparam = clog2(N)+1, width of each shift-count register.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (clk and rst naming per codebase; polarity and synchronicity fixed)
start  input  1  request; sampled only in IDLE
exact  input  1  0 = approximate (K bits), 1 = exact (N bits); latched with start
a  input  N  unsigned operand A; latched with start
b  input  N  unsigned operand B; latched with start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when product is valid
product  output  2N  result; held stable from done until next accepted start

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, product=0; all internal registers cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, NORM, MUL, DENORM, DONE.
- IDLE:
  - On start=1, latch ra=a, rb=b, mode=exact; clear sa, sb, acc.
  - If a==0 or b==0, go to DONE with product=0 (zero shortcut).
  - Otherwise go to NORM.
- NORM: each cycle, each operand with MSB=0 shifts left by 1 and increments its shift count (sa or sb).
  - When both MSBs are 1 in the current cycle, load the multiplier and go to MUL.
  - Duration is max(lz(a), lz(b))+1 cycles.
- MUL:
  - M = K if mode=0, else N.
  - Operands: ta = ra[N-1:N-M], tb = rb[N-1:N-M].
  - The {acc_hi, tb} register pair does M iterations of: if lsb then acc_hi += ta (carry kept), then shift right by 1.
  - A down-counter loaded with M-1 goes to DENORM at zero.
  - The 2M-bit result P equals ta*tb exactly.
- DENORM, single cycle:
  - product <= (P << (2N-2M)) >> (sa+sb), computed in 2N bits.
  - Bits shifted out at the bottom are discarded (truncation, no rounding).
  - Then go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- start:
  - Ignored in every state except IDLE, including DONE. Back-to-back throughput is one operation per (latency+1) cycles.
  - a, b and exact may change freely after acceptance.
- Latency, counted from the start-sampling edge to the edge after which done=1:
  - Nonzero operands: max(lz)+M+3 cycles.
  - Zero shortcut: 1 cycle.
- Exact mode (exact=1) yields product == a*b for all inputs.
- Approximate mode: product <= a*b always.
  - Result is exact whenever both operands have <= K significant bits.
- Width rules:
  - acc_hi is M+1 bits internally (sized for N).
  - sa+sb <= 2N-2 fits in SW+1 bits.
  - No overflow is possible in 2N bits.

Decomposition:
- Package approx_mul_pkg holds:
  - State encoding (IDLE=0, NORM=1, MUL=2, DENORM=3, DONE=4; 3 bits).
  - The clog2 function and the SW derivation.
- One sub-module, shift_add_core, parametrised by N:
  - Inputs: load, m_len, ta, tb.
  - Outputs: P, last.
  - Holds the acc/multiplier registers and the iteration counter.
  - Leading-one normalisation and denormalisation stay in the top level.

Test Plan:
- N=16, K=8, exact=0, a=0xFFFF, b=0xFFFF -> product=0xFE010000, done 11 cycles after start; same inputs with exact=1 -> 0xFFFE0001, done at 19 cycles.
- exact=0, a=0x0003, b=0x0005 -> sa=14, sb=13, ta=0xC0, tb=0xA0, product=0x0000000F, done at 25 cycles; busy high throughout.
- exact=0, a=0x1FFF, b=0x0100 -> product=0x001FE000 (exact value 0x001FFF00; verifies truncation error); with exact=1 -> 0x001FFF00.
- a=0x1234, b=0 -> product=0, done one cycle after start, no NORM/MUL states visited; prior product is overwritten.
- Pulse start during busy and during DONE -> ignored, product and latency unchanged; drop rst low mid-MUL -> busy=0, done=0, product=0 immediately (asynchronously), and a fresh start then completes normally.
- Randomised sweep of 1000 operand pairs in both modes against the reference model (exact: a*b; approx: formula above), checking that product stays stable between done and the next start.
